// File: rtl/esfa_request_arbiter.sv
// esfa_request_arbiter
// Shares one ESFADesign datapath between two requesters. Port 0 carries host
// commands from the sandbox link. Port 1 carries an on-chip requester such as
// a self-test or scrub engine. One command is in flight at a time. Each command
// is issued to the datapath, waits RESULT_LATENCY cycles for the result, and is
// returned as a status/data response to the port that issued it.
//
// Ports
//   masterClock, reset          clock; synchronous active-low reset
//   reqN_valid/ready            command handshake (ready is a one-cycle accept pulse)
//   reqN_control                bit0 mutating, bit1 isMeta, bit2 willWrite
//   reqN_data                   [7:0] index, [15:8] value, [23:16] metadata, [31:24] selector
//   rspN_valid/ready            response handshake; response is held until taken
//   rspN_status, rspN_data      bit0 result flag / [31:24] result value
//   esfa_*                      datapath operands (out) and results (in)
//   busy, grant                 not idle / one-hot owner of the command in flight
//
// Build option
//   ESFA_ARB_FIXED_PRIO_EN      port 0 always wins a simultaneous request, and
//                               no round-robin pointer is built; otherwise the
//                               requesters are served round-robin
//
// State | Meaning
// IDLE  | waiting for a request; ready pulses for the winner
// ISSUE | drive operands/strobes for the latched command, load wait counter
// WAIT  | count down the datapath latency, capture the result at terminal count
// RESP  | hold the response for the granted port until it is taken
module esfa_request_arbiter #(
  parameter int RESULT_LATENCY = 2
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_control,
  input  logic [31:0] req0_data,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [7:0]  rsp0_status,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_control,
  input  logic [31:0] req1_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [7:0]  rsp1_status,
  output logic [31:0] rsp1_data,
  output logic        esfa_willWrite,
  output logic        esfa_isMetadata,
  output logic [7:0]  esfa_new_index,
  output logic [7:0]  esfa_new_value,
  output logic [7:0]  esfa_metadata,
  output logic [7:0]  esfa_selector,
  input  logic        esfa_resultBool,
  input  logic [7:0]  esfa_resultValue,
  output logic        busy,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(RESULT_LATENCY);

  state_t      state;
  logic [2:0]  cmd_ctrl;
  logic [31:0] cmd_data;
  logic [3:0]  wait_cnt;
  logic        res_flag;
  logic [7:0]  res_value;
  logic        win0;
  logic        win1;
  logic        rsp_take;
  logic        unused_ctrl_bits;

  assign unused_ctrl_bits = ^{req0_control[7:3], req1_control[7:3]};

`ifdef ESFA_ARB_FIXED_PRIO_EN
  assign win0 = req0_valid;
  assign win1 = req1_valid & ~req0_valid;
`else
  // rr_next = 1 means port 1 has priority for the next simultaneous request
  logic rr_next;
  assign win0 = req0_valid & (~req1_valid | ~rr_next);
  assign win1 = req1_valid & (~req0_valid | rr_next);
`endif

  // Ready is masked by reset so no accept pulse is seen for a command that
  // the reset edge would drop.
  assign req0_ready = reset & (state == IDLE) & win0;
  assign req1_ready = reset & (state == IDLE) & win1;

  assign rsp_take = (grant[0] & rsp0_ready) | (grant[1] & rsp1_ready);
  assign busy     = (state != IDLE);

  assign rsp0_status = {7'b0, rsp0_valid & res_flag};
  assign rsp1_status = {7'b0, rsp1_valid & res_flag};
  assign rsp0_data   = rsp0_valid ? {res_value, 24'h0} : 32'h0;
  assign rsp1_data   = rsp1_valid ? {res_value, 24'h0} : 32'h0;

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      state           <= IDLE;
      cmd_ctrl        <= 3'b0;
      cmd_data        <= 32'h0;
      wait_cnt        <= 4'h0;
      res_flag        <= 1'b0;
      res_value       <= 8'h0;
      grant           <= 2'b00;
      rsp0_valid      <= 1'b0;
      rsp1_valid      <= 1'b0;
      esfa_willWrite  <= 1'b0;
      esfa_isMetadata <= 1'b0;
      esfa_new_index  <= 8'h0;
      esfa_new_value  <= 8'h0;
      esfa_metadata   <= 8'h0;
      esfa_selector   <= 8'h0;
`ifndef ESFA_ARB_FIXED_PRIO_EN
      rr_next         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win0 | win1) begin
            grant    <= {win1, win0};
            cmd_ctrl <= win1 ? req1_control[2:0] : req0_control[2:0];
            cmd_data <= win1 ? req1_data : req0_data;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // Queries leave operands and isMetadata untouched.
          if (cmd_ctrl[0]) begin
            esfa_new_index  <= cmd_data[7:0];
            esfa_new_value  <= cmd_data[15:8];
            esfa_metadata   <= cmd_data[23:16];
            esfa_selector   <= cmd_data[31:24];
            esfa_isMetadata <= cmd_ctrl[1];
            esfa_willWrite  <= cmd_ctrl[2];
          end else begin
            esfa_willWrite  <= 1'b0;
          end
          wait_cnt <= LAT;
          state    <= WAIT;
        end
        WAIT: begin
          esfa_willWrite <= 1'b0;
          // Terminal count of 1 puts the capture RESULT_LATENCY edges after
          // the operands were driven.
          if (wait_cnt == 4'd1) begin
            wait_cnt   <= 4'h0;
            res_flag   <= cmd_ctrl[0] ? 1'b1 : esfa_resultBool;
            res_value  <= cmd_ctrl[0] ? 8'h0 : esfa_resultValue;
            rsp0_valid <= grant[0];
            rsp1_valid <= grant[1];
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            grant      <= 2'b00;
`ifndef ESFA_ARB_FIXED_PRIO_EN
            rr_next    <= grant[0];
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
